// File: rtl/debug_uart_cmd_tx.sv
// debug_uart_cmd_tx: FIFO-buffered 8N1/8N2 UART transmitter driving the debugger command input
module debug_uart_cmd_tx #(
  parameter int DIVIDER_TICKS_WIDTH = 12,
  parameter int DIVIDER_TICKS = 1200,
  parameter int STOP_BITS = 2,
  parameter int FIFO_ADDR_WIDTH = 4
) (
  input  logic clk_in,
  input  logic reset,
  input  logic [7:0] data_in,
  input  logic data_valid,
  output logic data_ready,
  output logic tx_out,
  output logic busy,
  output logic [FIFO_ADDR_WIDTH:0] fifo_count
);
  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int CW = FIFO_ADDR_WIDTH + 1;
  localparam logic [DIVIDER_TICKS_WIDTH-1:0] TICK_MAX = DIVIDER_TICKS_WIDTH'(DIVIDER_TICKS - 1);
  localparam logic [2:0] STOP_MAX = 3'(STOP_BITS - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [DIVIDER_TICKS_WIDTH-1:0] tick;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_n;
  logic wrap, last, push, pop;
  assign busy = state != IDLE || fifo_count != '0;
  always_comb begin
    wrap = tick == TICK_MAX;
    last = wrap && (state == DATA ? bit_cnt == 3'd7 : bit_cnt == STOP_MAX);
    push = data_valid && data_ready;
    pop = fifo_count != '0 && (state == IDLE || (state == STOP && last));
    state_n = state == IDLE  ? (pop ? START : IDLE) :
              state == START ? (wrap ? DATA : START) :
              state == DATA  ? (last ? STOP : DATA) :
                               (last ? (pop ? START : IDLE) : STOP);
    count_n = fifo_count + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk_in)
    if (push) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= IDLE;
      tick <= '0;
      bit_cnt <= '0;
      shift <= '0;
      tx_out <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      data_ready <= 1'b0;
    end else begin
      state <= state_n;
      tick <= (state == IDLE || wrap) ? '0 : tick + DIVIDER_TICKS_WIDTH'(1);
      bit_cnt <= state != state_n ? 3'd0 : wrap ? bit_cnt + 3'd1 : bit_cnt;
      shift <= pop ? mem[rd_ptr] : (state == DATA && wrap) ? shift >> 1 : shift;
      tx_out <= state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
      wr_ptr <= wr_ptr + FIFO_ADDR_WIDTH'(push);
      rd_ptr <= rd_ptr + FIFO_ADDR_WIDTH'(pop);
      fifo_count <= count_n;
      data_ready <= count_n != FULL;
    end
  end
endmodule

// File: tb/tb_debug_uart_cmd_tx.sv
// tb_debug_uart_cmd_tx: directed/random bench decoding the serial line against queued bytes
module tb_debug_uart_cmd_tx;
  localparam int DA = 8, FA = 88, DB = 5, FB = 50;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a, dv_a, rdy_a, tx_a, busy_a, rst_b, dv_b, rdy_b, tx_b, busy_b;
  logic [7:0] d_a, d_b;
  logic [4:0] cnt_a, cnt_b;
  int cyc = 0;
  int checks = 0, failures = 0;
  always @(posedge clk) cyc <= cyc + 1;
  debug_uart_cmd_tx #(.DIVIDER_TICKS_WIDTH(12), .DIVIDER_TICKS(DA), .STOP_BITS(2), .FIFO_ADDR_WIDTH(4)) dut_a (
    .clk_in(clk), .reset(rst_a), .data_in(d_a), .data_valid(dv_a), .data_ready(rdy_a),
    .tx_out(tx_a), .busy(busy_a), .fifo_count(cnt_a));
  debug_uart_cmd_tx #(.DIVIDER_TICKS_WIDTH(12), .DIVIDER_TICKS(DB), .STOP_BITS(1), .FIFO_ADDR_WIDTH(4)) dut_b (
    .clk_in(clk), .reset(rst_b), .data_in(d_b), .data_valid(dv_b), .data_ready(rdy_b),
    .tx_out(tx_b), .busy(busy_b), .fifo_count(cnt_b));
  int pa = -1, la, ferr_a = 0, pb = -1, lb, ferr_b = 0;
  logic [7:0] ba, bb;
  logic [7:0] ga[$], gb[$];
  int sa[$], sb[$], lowa[$], lowb[$];
  always @(negedge clk) begin
    if (rst_a) pa = -1;
    else if (pa >= 0 && pa + 1 < FA) begin
      pa++;
      if (!tx_a) la++;
      if (pa % DA == DA / 2) begin
        if (pa / DA >= 1 && pa / DA <= 8) ba[pa / DA - 1] = tx_a;
        else if (tx_a !== (pa / DA != 0)) ferr_a++;
      end
    end else begin
      if (pa >= 0) begin ga.push_back(ba); lowa.push_back(la); end
      pa = -1;
      if (!tx_a) begin pa = 0; la = 1; ba = '0; sa.push_back(cyc); end
    end
  end
  always @(negedge clk) begin
    if (rst_b) pb = -1;
    else if (pb >= 0 && pb + 1 < FB) begin
      pb++;
      if (!tx_b) lb++;
      if (pb % DB == DB / 2) begin
        if (pb / DB >= 1 && pb / DB <= 8) bb[pb / DB - 1] = tx_b;
        else if (tx_b !== (pb / DB != 0)) ferr_b++;
      end
    end else begin
      if (pb >= 0) begin gb.push_back(bb); lowb.push_back(lb); end
      pb = -1;
      if (!tx_b) begin pb = 0; lb = 1; bb = '0; sb.push_back(cyc); end
    end
  end
  int mx_a = 0, rdy_err = 0;
  task automatic step();
    @(posedge clk);
    #1;
    if (32'(cnt_a) > mx_a) mx_a = 32'(cnt_a);
    if (!rst_a && rdy_a !== (cnt_a != 5'd16)) rdy_err++;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_bytes(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
    chk({tag, "_len"}, got.size(), exp.size());
    foreach (exp[i]) chk(tag, i < got.size() ? {24'd0, got[i]} : 'x, {24'd0, exp[i]});
  endtask
  task automatic wait_idle_a(input string tag, input int bound);
    int n = 0;
    while (busy_a && n < bound) begin step(); n++; end
    chk(tag, busy_a, 0);
  endtask
  task automatic clear_a();
    ga.delete(); sa.delete(); lowa.delete();
  endtask
  function automatic logic exp_bit(logic [7:0] b, int j, int dt);
    int k = j / dt;
    return j < 0 ? 1'b1 : k == 0 ? 1'b0 : k <= 8 ? b[k-1] : 1'b1;
  endfunction
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  logic [7:0] exp[$];
  logic [7:0] v;
  int t0, n, werr, lows;
  initial begin
    rst_a = 1; rst_b = 1; dv_a = 0; dv_b = 0; d_a = 0; d_b = 0;
    step();
    chk("rst_tx", tx_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_rdy", rdy_a, 0);
    rst_a = 0; rst_b = 0;
    step();
    chk("rdy_after_rst", rdy_a, 1);
    lows = 0;
    repeat (200) begin step(); if (!tx_a) lows++; end
    chk("idle_tx_high", lows, 0);
    chk("idle_no_frames", sa.size(), 0);
    clear_a();
    dv_a = 1; d_a = 8'h30;
    step();
    dv_a = 0;
    chk("push_cnt", cnt_a, 1);
    step();
    chk("pop_tx_high", tx_a, 1);
    chk("pop_cnt", cnt_a, 0);
    chk("pop_busy", busy_a, 1);
    step();
    chk("start_tx_low", tx_a, 0);
    t0 = cyc; werr = 0; n = 0;
    while (busy_a && n < 200) begin
      if (tx_a !== exp_bit(8'h30, cyc - t0, DA)) werr++;
      step(); n++;
    end
    chk("busy_fall_after_start_entry", cyc - (t0 - 1), 88);
    chk("wave_30", werr, 0);
    repeat (3) step();
    exp.delete(); exp.push_back(8'h30);
    chk_bytes("dec_30", ga, exp);
    clear_a(); mx_a = 0;
    exp.delete(); exp.push_back(8'h4C); exp.push_back(8'h20); exp.push_back(8'h52);
    foreach (exp[i]) begin dv_a = 1; d_a = exp[i]; step(); end
    dv_a = 0;
    wait_idle_a("lrr_idle", 400);
    repeat (3) step();
    chk_bytes("lrr", ga, exp);
    chk("lrr_gap1", sa.size() == 3 ? sa[1] - sa[0] : -1, FA);
    chk("lrr_gap2", sa.size() == 3 ? sa[2] - sa[1] : -1, FA);
    chk("lrr_fifo_peak", mx_a, 2);
    clear_a(); mx_a = 0; rdy_err = 0; exp.delete();
    v = 8'($urandom_range(0, 255));
    repeat (40) begin
      dv_a = 1; d_a = v;
      if (rdy_a) exp.push_back(v);
      step();
      v++;
    end
    dv_a = 0;
    chk("hold_peak", mx_a, 16);
    chk("hold_accepted", exp.size(), 17);
    chk("hold_rdy_vs_full", rdy_err, 0);
    wait_idle_a("hold_idle", 3000);
    repeat (3) step();
    chk_bytes("hold", ga, exp);
    clear_a(); exp.delete();
    repeat (6) begin
      v = 8'($urandom);
      dv_a = 1; d_a = v; exp.push_back(v);
      step();
      dv_a = 0;
      repeat ($urandom_range(0, 3)) step();
    end
    wait_idle_a("rand_idle", 1000);
    repeat (3) step();
    chk_bytes("rand", ga, exp);
    clear_a(); exp.delete();
    repeat (3) begin v = 8'($urandom); exp.push_back(v); dv_a = 1; d_a = v; step(); end
    dv_a = 0;
    n = 0;
    while (sa.size() < 2 && n < 400) begin step(); n++; end
    chk("abort_second_frame_seen", sa.size(), 2);
    repeat (42) step();
    rst_a = 1;
    step();
    chk("abort_tx", tx_a, 1);
    chk("abort_cnt", cnt_a, 0);
    chk("abort_busy", busy_a, 0);
    rst_a = 0;
    lows = 0;
    repeat (300) begin step(); if (!tx_a) lows++; end
    chk("abort_line_idle", lows, 0);
    chk("abort_no_new_frame", sa.size(), 2);
    v = exp[0]; exp.delete(); exp.push_back(v);
    chk_bytes("abort_first_only", ga, exp);
    clear_a();
    dv_a = 1; d_a = 8'h62;
    step();
    dv_a = 0;
    wait_idle_a("after_abort_idle", 400);
    repeat (3) step();
    exp.delete(); exp.push_back(8'h62);
    chk_bytes("after_abort", ga, exp);
    dv_b = 1; d_b = 8'hFF;
    step();
    d_b = 8'h00;
    step();
    dv_b = 0;
    n = 0;
    while (busy_b && n < 400) begin step(); n++; end
    chk("sb1_idle", busy_b, 0);
    t0 = cyc;
    repeat (3) step();
    exp.delete(); exp.push_back(8'hFF); exp.push_back(8'h00);
    chk_bytes("sb1", gb, exp);
    chk("sb1_busy_span", sb.size() > 0 ? t0 - (sb[0] - 1) : -1, 100);
    chk("sb1_gap", sb.size() == 2 ? sb[1] - sb[0] : -1, FB);
    chk("sb1_low_ff", lowb.size() == 2 ? lowb[0] : -1, 5);
    chk("sb1_low_00", lowb.size() == 2 ? lowb[1] : -1, 45);
    chk("framing_a", ferr_a, 0);
    chk("framing_b", ferr_b, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
